// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a word-addressed RAM with independent read and write burst engines.
// Optional out-of-range SLVERR reporting is enabled with macro AXI_RAM_ERR_RESP_EN.
module axi_ram_slave #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // AR
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // R
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // AW
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // W
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // B
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [31:0] mem [MEM_WORDS];

  // WRAP keeps the upper address bits and lets only the in-window offset roll over.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr + step;
    endcase
  endfunction

  logic [0:0]  r_state;
  logic [3:0]  r_id;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_beat;

  logic [1:0]  w_state;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [3:0]  w_len;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic [3:0]  w_beat;
  logic        w_err_acc;

  logic [31:0]      rd_off;
  logic [31:0]      wr_off;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_err;
  logic             wr_err;
  logic             mem_we;

  assign rd_off = r_addr - BASE_ADDR;
  assign wr_off = w_addr - BASE_ADDR;
  assign rd_idx = rd_off[IDX_W+1:2];
  assign wr_idx = wr_off[IDX_W+1:2];

`ifdef AXI_RAM_ERR_RESP_EN
  localparam logic [32:0] SPAN_BYTES = 33'(MEM_WORDS) << 2;
  // Subtraction wraps below BASE_ADDR, so those addresses also land out of range.
  assign rd_err = ({1'b0, rd_off} >= SPAN_BYTES);
  assign wr_err = ({1'b0, wr_off} >= SPAN_BYTES);
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
`endif

  assign arready = (r_state == R_IDLE) && !i_rst;
  assign rvalid  = (r_state == R_BURST);
  assign rlast   = rvalid && (r_beat == r_len);
  assign rid     = r_id;
  assign rdata   = (rvalid && !rd_err) ? mem[rd_idx] : '0;
  assign rresp   = (rvalid && rd_err) ? 2'b10 : 2'b00;

  assign awready = (w_state == W_IDLE) && !i_rst;
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = w_id;
  assign bresp   = (bvalid && w_err_acc) ? 2'b10 : 2'b00;

  assign mem_we  = wvalid && wready && !wr_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
    end else if (r_state == R_IDLE) begin
      if (arvalid) begin
        r_id    <= arid;
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_beat  <= '0;
        r_state <= R_BURST;
      end
    end else if (rready) begin
      if (r_beat == r_len) begin
        r_state <= R_IDLE;
      end else begin
        r_beat <= r_beat + 4'd1;
        r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_beat    <= '0;
      w_err_acc <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_id      <= awid;
            w_addr    <= awaddr;
            w_len     <= awlen;
            w_size    <= awsize;
            w_burst   <= awburst;
            w_beat    <= '0;
            w_err_acc <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_err_acc <= w_err_acc | wr_err;
            // Termination follows the beat count; wlast is not trusted.
            if (w_beat == w_len) begin
              w_state <= W_RESP;
            end else begin
              w_beat <= w_beat + 4'd1;
              w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // No reset on the array: contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast,
                        rd_off, wr_off};

endmodule
